// File: rtl/gpu_burst_pkg.sv
// gpu_burst_pkg
// Shared types and constants for the GPU RAM host-port burst master.
//   burst_op_t    : command opcode as presented on cmd_op
//   burst_state_t : sequencer states of gpu_host_burst_master
//   STEP_8/STEP_16: address increment for byte and 16-bit word bursts
package gpu_burst_pkg;

    typedef enum logic [1:0] {
        OP_WRITE = 2'd0,
        OP_READ  = 2'd1,
        OP_FILL  = 2'd2,
        OP_NOP   = 2'd3
    } burst_op_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_READ,
        S_FILL,
        S_DRAIN,
        S_DONE
    } burst_state_t;

    localparam int STEP_8  = 1;
    localparam int STEP_16 = 2;

endpackage

// File: rtl/gpu_burst_rd_fifo.sv
// gpu_burst_rd_fifo
// Read-return FIFO, DEPTH x 16, first-word fall-through: head_data shows the
// oldest entry whenever empty is low, and reads as zero when empty.
// Ports:
//   clk        : clock, posedge
//   clear      : synchronous clear of pointers and count
//   push       : write push_data this clock
//   push_data  : 16-bit word to store
//   pop        : drop the head entry this clock (ignored when empty)
//   head_data  : current head word
//   empty      : no entries stored
//   count      : number of stored entries, 0..DEPTH
import gpu_burst_pkg::*;

module gpu_burst_rd_fifo #(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     clear,
    input  logic                     push,
    input  logic [15:0]              push_data,
    input  logic                     pop,
    output logic [15:0]              head_data,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = DEPTH[AW:0];

    logic [15:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    // A push is still taken when full if a pop frees a slot in the same clock.
    assign do_pop  = pop && (count != '0);
    assign do_push = push && ((count != FULL_COUNT) || do_pop);

    assign empty     = (count == '0);
    assign head_data = empty ? 16'h0000 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/gpu_host_burst_master.sv
// gpu_host_burst_master
// Host-side initiator for the GPU RAM host port. Runs one WRITE, READ or FILL
// burst at a time, one single-word access per clock with address
// auto-increment (wrapping modulo 2**ADDR_BITS), valid/ready on both streams.
// Ports:
//   clk, reset                : clock and synchronous active-high reset
//   cmd_*                     : command channel (valid/ready, op, addr, len,
//                               16-bit mode, fill value)
//   wr_valid/wr_ready/wr_data : write-data stream into the master
//   rd_valid/rd_ready/rd_data : read-data stream out of the master
//   host_*/ena_host_16bit     : GPU RAM host port
//   busy, done                : status; done pulses one clock per command
// Optional build macro GPU_BURST_STATS_EN adds stat_clr (in) and
// stat_words[31:0] (out), counting host writes plus read words returned.
import gpu_burst_pkg::*;

module gpu_host_burst_master #(
    parameter int ADDR_BITS  = 20,
    parameter int LEN_BITS   = 12,
    parameter int RD_LATENCY = 3,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [1:0]           cmd_op,
    input  logic [ADDR_BITS-1:0] cmd_addr,
    input  logic [LEN_BITS-1:0]  cmd_len,
    input  logic                 cmd_16bit,
    input  logic [15:0]          cmd_fill_data,
    input  logic                 wr_valid,
    output logic                 wr_ready,
    input  logic [15:0]          wr_data,
    output logic                 rd_valid,
    input  logic                 rd_ready,
    output logic [15:0]          rd_data,
    output logic                 host_wr_ena,
    output logic [ADDR_BITS-1:0] host_addr,
    output logic [15:0]          host_wr_data,
    output logic                 ena_host_16bit,
    input  logic [15:0]          host_rd_data,
    output logic                 busy,
`ifdef GPU_BURST_STATS_EN
    input  logic                 stat_clr,
    output logic [31:0]          stat_words,
`endif
    output logic                 done
);

    localparam int FCW = $clog2(FIFO_DEPTH) + 1;
    localparam int IW  = $clog2(RD_LATENCY + 1);
    localparam int SW  = $clog2(FIFO_DEPTH + RD_LATENCY) + 1;

    burst_state_t          state;
    logic [ADDR_BITS-1:0]  cur;
    logic [ADDR_BITS-1:0]  next_cur;
    logic [LEN_BITS-1:0]   remaining;
    logic [15:0]           fill_q;
    logic [RD_LATENCY-1:0] vld;
    logic [IW-1:0]         inflight;
    logic [FCW-1:0]        fifo_count;
    logic                  fifo_empty;
    logic                  fifo_push;
    logic                  room;
    logic                  rd_issue;
    logic                  wr_beat;
    logic                  fill_issue;

    assign cmd_ready = (state == S_IDLE);
    assign busy      = (state != S_IDLE);
    assign done      = (state == S_DONE);
    assign rd_valid  = !fifo_empty;

    // Address step follows the latched word size, wrapping at the address width.
    assign next_cur = cur + (ena_host_16bit ? ADDR_BITS'(STEP_16) : ADDR_BITS'(STEP_8));

    // Reads already issued but not yet captured.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < RD_LATENCY; i++) begin
            inflight = inflight + IW'(vld[i]);
        end
    end

    // Counting in-flight reads against free FIFO space guarantees every
    // returning word has a slot, whatever the consumer does.
    assign room       = (SW'(fifo_count) + SW'(inflight)) < SW'(FIFO_DEPTH);
    assign rd_issue   = (state == S_READ) && (remaining != '0) && room;
    assign wr_beat    = (state == S_WRITE) && wr_valid && wr_ready;
    assign fill_issue = (state == S_FILL) && (remaining != '0);
    assign fifo_push  = vld[RD_LATENCY-1];

    // Sequencer: registered host port, write-ready and read-tag pipe. After the
    // final write beat the state lingers one clock in WRITE/FILL so the strobe
    // is never visible in DONE.
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= S_IDLE;
            cur            <= '0;
            remaining      <= '0;
            fill_q         <= '0;
            host_wr_ena    <= 1'b0;
            host_addr      <= '0;
            host_wr_data   <= '0;
            ena_host_16bit <= 1'b0;
            wr_ready       <= 1'b0;
            vld            <= '0;
        end else begin
            host_wr_ena <= 1'b0;
            vld[0]      <= rd_issue;
            for (int i = 1; i < RD_LATENCY; i++) begin
                vld[i] <= vld[i-1];
            end
            case (state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        cur            <= cmd_addr;
                        remaining      <= cmd_len;
                        fill_q         <= cmd_fill_data;
                        ena_host_16bit <= cmd_16bit;
                        if (cmd_len == '0) begin
                            state <= S_DONE;
                        end else begin
                            case (burst_op_t'(cmd_op))
                                OP_WRITE: begin
                                    state    <= S_WRITE;
                                    wr_ready <= 1'b1;
                                end
                                OP_READ:  state <= S_READ;
                                OP_FILL:  state <= S_FILL;
                                default:  state <= S_DONE;
                            endcase
                        end
                    end
                end
                S_WRITE: begin
                    if (remaining == '0) begin
                        state <= S_DONE;
                    end else if (wr_beat) begin
                        host_wr_ena  <= 1'b1;
                        host_addr    <= cur;
                        host_wr_data <= wr_data;
                        cur          <= next_cur;
                        remaining    <= remaining - LEN_BITS'(1);
                        if (remaining == LEN_BITS'(1)) begin
                            wr_ready <= 1'b0;
                        end
                    end
                end
                S_FILL: begin
                    if (fill_issue) begin
                        host_wr_ena  <= 1'b1;
                        host_addr    <= cur;
                        host_wr_data <= fill_q;
                        cur          <= next_cur;
                        remaining    <= remaining - LEN_BITS'(1);
                    end else begin
                        state <= S_DONE;
                    end
                end
                S_READ: begin
                    if (rd_issue) begin
                        host_addr <= cur;
                        cur       <= next_cur;
                        remaining <= remaining - LEN_BITS'(1);
                        if (remaining == LEN_BITS'(1)) begin
                            state <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (inflight == '0) begin
                        state <= S_DONE;
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    gpu_burst_rd_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_rd_fifo (
        .clk       (clk),
        .clear     (reset),
        .push      (fifo_push),
        .push_data (host_rd_data),
        .pop       (rd_ready),
        .head_data (rd_data),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

`ifdef GPU_BURST_STATS_EN
    // Clear beats a same-cycle increment; counter wraps at 2**32.
    always_ff @(posedge clk) begin
        if (reset || stat_clr) begin
            stat_words <= '0;
        end else begin
            stat_words <= stat_words + 32'(wr_beat || fill_issue) + 32'(fifo_push);
        end
    end
`endif

endmodule

// File: tb/tb_gpu_host_burst_master.sv
// tb_gpu_host_burst_master
// Self-checking bench for gpu_host_burst_master. A host-port memory model
// returns a fixed function of the address two register stages after it is
// presented (captured by the master three clocks after issue). Expected
// traffic is computed from burst arithmetic: address base + i*step, modulo
// 2**20, with the fill value or the supplied write data.
module tb_gpu_host_burst_master;

    localparam int AB = 20;
    localparam int LB = 12;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [1:0]    cmd_op = 2'd0;
    logic [AB-1:0] cmd_addr = '0;
    logic [LB-1:0] cmd_len = '0;
    logic          cmd_16bit = 1'b0;
    logic [15:0]   cmd_fill_data = '0;
    logic          wr_valid = 1'b0;
    logic          wr_ready;
    logic [15:0]   wr_data = '0;
    logic          rd_valid;
    logic          rd_ready = 1'b0;
    logic [15:0]   rd_data;
    logic          host_wr_ena;
    logic [AB-1:0] host_addr;
    logic [15:0]   host_wr_data;
    logic          ena_host_16bit;
    logic [15:0]   host_rd_data;
    logic          busy;
    logic          done;
`ifdef GPU_BURST_STATS_EN
    logic          stat_clr = 1'b0;
    logic [31:0]   stat_words;
`endif

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int done_count = 0;

    logic [AB-1:0] wr_addr_q [$];
    logic [15:0]   wr_data_q [$];
    int            wr_cyc_q  [$];
    logic [15:0]   rd_q      [$];
    logic [15:0]   wr_src_q  [$];

    logic [AB-1:0] addr_d1;
    logic [AB-1:0] addr_d2;

    gpu_host_burst_master dut (
        .clk            (clk),
        .reset          (reset),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_op         (cmd_op),
        .cmd_addr       (cmd_addr),
        .cmd_len        (cmd_len),
        .cmd_16bit      (cmd_16bit),
        .cmd_fill_data  (cmd_fill_data),
        .wr_valid       (wr_valid),
        .wr_ready       (wr_ready),
        .wr_data        (wr_data),
        .rd_valid       (rd_valid),
        .rd_ready       (rd_ready),
        .rd_data        (rd_data),
        .host_wr_ena    (host_wr_ena),
        .host_addr      (host_addr),
        .host_wr_data   (host_wr_data),
        .ena_host_16bit (ena_host_16bit),
        .host_rd_data   (host_rd_data),
        .busy           (busy),
`ifdef GPU_BURST_STATS_EN
        .stat_clr       (stat_clr),
        .stat_words     (stat_words),
`endif
        .done           (done)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] memWord(input logic [AB-1:0] a);
        return a[15:0] ^ {a[19:16], a[19:16], a[19:16], a[19:16]} ^ 16'h5A3C;
    endfunction

    function automatic logic [AB-1:0] nthAddr(input logic [AB-1:0] base, input int i, input logic b16);
        logic [31:0] s;
        s = 32'(base) + 32'(i) * (b16 ? 32'd2 : 32'd1);
        return s[AB-1:0];
    endfunction

    // Host-port memory: address passes two registers, then the data word is
    // presented combinationally so the master captures it three clocks on.
    always @(posedge clk) begin
        addr_d1 <= host_addr;
        addr_d2 <= addr_d1;
    end
    assign host_rd_data = memWord(addr_d2);

    // Count clock edges so observed events can be placed in time.
    always @(posedge clk) cyc <= cyc + 1;

    // Observe the DUT mid-cycle: host writes, done pulses and read-stream pops.
    always @(negedge clk) begin
        if (host_wr_ena === 1'b1) begin
            wr_addr_q.push_back(host_addr);
            wr_data_q.push_back(host_wr_data);
            wr_cyc_q.push_back(cyc);
        end
        if (done === 1'b1) done_count++;
        if (rd_valid === 1'b1 && rd_ready === 1'b1) rd_q.push_back(rd_data);
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests++;
        assert (observed === expected) else begin
            fails++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Present one command; returns just after the edge that accepted it.
    task automatic applyStimulus(input logic [1:0] op, input logic [AB-1:0] addr, input logic [LB-1:0] len,
                                 input logic b16, input logic [15:0] fill);
        @(posedge clk); #1;
        cmd_valid = 1'b1;
        cmd_op = op;
        cmd_addr = addr;
        cmd_len = len;
        cmd_16bit = b16;
        cmd_fill_data = fill;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic waitDone(input int d0, input string tag);
        int t = 0;
        while (done_count == d0 && t < 500) begin
            @(negedge clk);
            t++;
        end
        checkOutput(tag, 32'(done_count != d0), 32'd1);
    endtask

    // Feed wr_src_q; mode 0 = always valid, 1 = random valid, 2 = 1,0,1,1 then valid.
    task automatic driveWrite(input int mode, input int d0);
        int idx = 0;
        int t = 0;
        logic [3:0] pattern = 4'b1101;
        logic want;
        while (done_count == d0 && t < 500) begin
            case (mode)
                0:       want = 1'b1;
                1:       want = ($urandom_range(0, 1) == 1);
                default: want = (t < 4) ? pattern[t] : 1'b1;
            endcase
            wr_valid = want && (idx < wr_src_q.size());
            wr_data = (idx < wr_src_q.size()) ? wr_src_q[idx] : 16'hDEAD;
            @(negedge clk);
            if (wr_valid && wr_ready) idx++;
            @(posedge clk); #1;
            t++;
        end
        wr_valid = 1'b0;
        checkOutput("write_finished", 32'(t < 500), 32'd1);
    endtask

    // Consume read words with a randomly stalling consumer until the burst is done.
    task automatic driveRead(input int n_words, input int r0, input int d0);
        int t = 0;
        while (((rd_q.size() - r0) < n_words || done_count == d0) && t < 1000) begin
            rd_ready = ($urandom_range(0, 3) != 0);
            @(posedge clk); #1;
            t++;
        end
        rd_ready = 1'b0;
        checkOutput("read_finished", 32'(t < 1000), 32'd1);
    endtask

    task automatic compareWrites(input string tag, input int w0, input logic [AB-1:0] base, input int len,
                                 input logic b16, input logic use_fill, input logic [15:0] fill);
        checkOutput({tag, "_count"}, 32'(wr_addr_q.size() - w0), 32'(len));
        for (int i = 0; i < len && (w0 + i) < wr_addr_q.size(); i++) begin
            checkOutput({tag, "_addr"}, 32'(wr_addr_q[w0 + i]), 32'(nthAddr(base, i, b16)));
            checkOutput({tag, "_data"}, 32'(wr_data_q[w0 + i]), 32'(use_fill ? fill : wr_src_q[i]));
        end
    endtask

    task automatic compareReads(input string tag, input int r0, input logic [AB-1:0] base, input int len,
                                input logic b16);
        checkOutput({tag, "_count"}, 32'(rd_q.size() - r0), 32'(len));
        for (int i = 0; i < len && (r0 + i) < rd_q.size(); i++) begin
            checkOutput({tag, "_data"}, 32'(rd_q[r0 + i]), 32'(memWord(nthAddr(base, i, b16))));
        end
    endtask

    initial begin
        int d0;
        int w0;
        int r0;
        int flag;
        logic [AB-1:0] base;
        logic [15:0] fill;

        // Step 1: reset state.
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        checkOutput("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_wr_ena", 32'(host_wr_ena), 32'd0);
        checkOutput("rst_host_addr", 32'(host_addr), 32'd0);
        checkOutput("rst_rd_valid", 32'(rd_valid), 32'd0);
        checkOutput("rst_wr_ready", 32'(wr_ready), 32'd0);

        // Step 2: FILL of four 16-bit words at 0x100.
        d0 = done_count; w0 = wr_addr_q.size();
        applyStimulus(2'd2, 20'h00100, 12'd4, 1'b1, 16'hA5A5);
        waitDone(d0, "fill_done");
        @(negedge clk);
        compareWrites("fill", w0, 20'h00100, 4, 1'b1, 1'b1, 16'hA5A5);
        checkOutput("fill_consecutive", 32'(wr_cyc_q[wr_cyc_q.size() - 1] - wr_cyc_q[w0]), 32'd3);
        checkOutput("fill_done_once", 32'(done_count - d0), 32'd1);
        checkOutput("fill_cmd_ready", 32'(cmd_ready), 32'd1);

        // Step 3: byte WRITE with a gap in wr_valid.
        wr_src_q = '{16'h0011, 16'h0022, 16'h0033};
        base = 20'($urandom);
        d0 = done_count; w0 = wr_addr_q.size();
        applyStimulus(2'd0, base, 12'd3, 1'b0, 16'h0000);
        driveWrite(2, d0);
        @(negedge clk);
        compareWrites("wgap", w0, base, 3, 1'b0, 1'b0, 16'h0000);
        checkOutput("wgap_gap_cycle", 32'(wr_cyc_q[w0 + 1] - wr_cyc_q[w0]), 32'd2);
        checkOutput("wgap_back_to_back", 32'(wr_cyc_q[w0 + 2] - wr_cyc_q[w0 + 1]), 32'd1);

        // Step 4: READ of 20 words with consumer stalled; busy commands ignored.
        base = {20'($urandom) & 20'hFFFFE};
        d0 = done_count; w0 = wr_addr_q.size(); r0 = rd_q.size();
        applyStimulus(2'd1, base, 12'd20, 1'b1, 16'h0000);
        cmd_valid = 1'b1; cmd_op = 2'd2; cmd_len = 12'd5;
        repeat (30) @(negedge clk);
        checkOutput("rstall_last_addr", 32'(host_addr), 32'(nthAddr(base, 7, 1'b1)));
        checkOutput("rstall_rd_valid", 32'(rd_valid), 32'd1);
        checkOutput("rstall_busy", 32'(busy), 32'd1);
        checkOutput("rstall_no_done", 32'(done_count - d0), 32'd0);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        driveRead(20, r0, d0);
        compareReads("rd20", r0, base, 20, 1'b1);
        checkOutput("rd20_no_writes", 32'(wr_addr_q.size() - w0), 32'd0);

        // Step 5: 16-bit WRITE across the top of the address space.
        wr_src_q = '{16'($urandom), 16'($urandom)};
        d0 = done_count; w0 = wr_addr_q.size();
        applyStimulus(2'd0, 20'hFFFFE, 12'd2, 1'b1, 16'h0000);
        driveWrite(0, d0);
        @(negedge clk);
        compareWrites("wwrap", w0, 20'hFFFFE, 2, 1'b1, 1'b0, 16'h0000);

        // Step 6: zero-length and reserved-op commands.
        d0 = done_count; w0 = wr_addr_q.size();
        applyStimulus(2'd0, 20'h00040, 12'd0, 1'b0, 16'h0000);
        @(negedge clk);
        checkOutput("len0_done", 32'(done), 32'd1);
        @(negedge clk);
        checkOutput("len0_done_low", 32'(done), 32'd0);
        checkOutput("len0_cmd_ready", 32'(cmd_ready), 32'd1);
        applyStimulus(2'd3, 20'h00080, 12'd5, 1'b1, 16'h1234);
        @(negedge clk);
        checkOutput("nop_done", 32'(done), 32'd1);
        @(negedge clk);
        checkOutput("nop_pulses", 32'(done_count - d0), 32'd2);
        checkOutput("nop_no_writes", 32'(wr_addr_q.size() - w0), 32'd0);

        // Step 7: reset during a READ with three reads in flight.
        base = 20'h20000;
        d0 = done_count;
        applyStimulus(2'd1, base, 12'd10, 1'b1, 16'h0000);
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("mid_third_issue", 32'(host_addr), 32'(nthAddr(base, 2, 1'b1)));
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        checkOutput("mid_rst_wr_ena", 32'(host_wr_ena), 32'd0);
        checkOutput("mid_rst_addr", 32'(host_addr), 32'd0);
        checkOutput("mid_rst_16bit", 32'(ena_host_16bit), 32'd0);
        checkOutput("mid_rst_busy", 32'(busy), 32'd0);
        checkOutput("mid_rst_cmd_ready", 32'(cmd_ready), 32'd1);
        checkOutput("mid_rst_rd_data", 32'(rd_data), 32'd0);
        flag = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (rd_valid !== 1'b0) flag = 1;
        end
        checkOutput("mid_rst_rd_valid_quiet", 32'(flag), 32'd0);
        checkOutput("mid_rst_no_done", 32'(done_count - d0), 32'd0);
        fill = 16'($urandom);
        base = 20'($urandom);
        d0 = done_count; w0 = wr_addr_q.size();
        applyStimulus(2'd2, base, 12'd3, 1'b0, fill);
        waitDone(d0, "post_rst_fill_done");
        @(negedge clk);
        compareWrites("post_rst_fill", w0, base, 3, 1'b0, 1'b1, fill);

        // Step 8: randomized commands with random flow control.
        for (int n = 0; n < 8; n++) begin
            int op;
            int len;
            logic b16;
            op = int'($urandom_range(0, 2));
            len = int'($urandom_range(1, 12));
            b16 = ($urandom_range(0, 1) == 1);
            base = 20'($urandom);
            fill = 16'($urandom);
            d0 = done_count; w0 = wr_addr_q.size(); r0 = rd_q.size();
            wr_src_q.delete();
            for (int i = 0; i < len; i++) wr_src_q.push_back(16'($urandom));
            applyStimulus(2'(op), base, LB'(len), b16, fill);
            if (op == 0) begin
                driveWrite(1, d0);
                @(negedge clk);
                compareWrites("rnd_write", w0, base, len, b16, 1'b0, 16'h0000);
            end else if (op == 1) begin
                driveRead(len, r0, d0);
                compareReads("rnd_read", r0, base, len, b16);
            end else begin
                waitDone(d0, "rnd_fill_done");
                @(negedge clk);
                compareWrites("rnd_fill", w0, base, len, b16, 1'b1, fill);
            end
            checkOutput("rnd_done_once", 32'(done_count - d0), 32'd1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Guard against a stuck run.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/gpu_host_burst_master.md
Name: gpu_host_burst_master

Overview:
Host-side initiator for the GPU RAM host port (host_wr_ena / host_addr / host_wr_data / ena_host_16bit / host_rd_data). It accepts one burst command at a time: a write burst, a read burst or a fill. It sequences single-word accesses at one per clock, with address auto-increment and valid/ready flow control on both data streams. It sits between a bus bridge or DMA source and the video generator's host port, in the host_clk domain.

Parameters:
ADDR_BITS, 20, host address width; addresses wrap modulo 2**ADDR_BITS.
LEN_BITS, 12, width of the burst word count.
RD_LATENCY, 3, clocks from a read address on host_addr to valid host_rd_data; must be 1..8.
FIFO_DEPTH, 8, read-return FIFO entries; power of 2, and must be at least RD_LATENCY.

Ports:
clk  in  1  host clock; all logic on posedge.
reset  in  1  synchronous, active-high.
cmd_valid  in  1  command offered.
cmd_ready  out  1  high only in IDLE.
cmd_op  in  2  0 = WRITE, 1 = READ, 2 = FILL, 3 = reserved (treated as no-op).
cmd_addr  in  ADDR_BITS  burst start address.
cmd_len  in  LEN_BITS  word count; 0 = no-op.
cmd_16bit  in  1  1 = 16-bit words with address step 2; 0 = bytes with step 1.
cmd_fill_data  in  16  FILL value.
wr_valid / wr_ready  in / out  1  write-data stream handshake.
wr_data  in  16  write data.
rd_valid / rd_ready  out / in  1  read-data stream handshake.
rd_data  out  16  read data, in address order.
host_wr_ena  out  1  write strobe to the GPU RAM host port.
host_addr  out  ADDR_BITS  access address.
host_wr_data  out  16  write data to the host port.
ena_host_16bit  out  1  latched copy of cmd_16bit.
host_rd_data  in  16  read data from the host port.
busy  out  1  high when not in IDLE.
done  out  1  one-clock pulse when a command completes.

Behaviour:
- Reset values:
  - Outputs: host_wr_ena=0, host_addr=0, host_wr_data=0, ena_host_16bit=0, wr_ready=0, rd_valid=0, rd_data=0, busy=0, done=0, cmd_ready=1 (the next clock after reset).
  - Internal: FIFO emptied, in-flight pipe cleared, state IDLE.
- States: IDLE, WRITE, READ, FILL, DRAIN, DONE.
- Command acceptance:
  - A command is accepted in IDLE when cmd_valid is high (cmd_ready is high throughout IDLE).
  - On acceptance, latch addr, len, op, 16bit and fill data, then move to WRITE, READ or FILL.
  - len=0 or op=3 goes straight to DONE.
- WRITE:
  - wr_ready=1.
  - Each wr_valid&wr_ready beat registers host_wr_ena=1, host_addr=cur, host_wr_data=wr_data on the next clock.
  - Each beat advances cur by the step and decrements remaining.
  - After the last beat, go to DONE.
- FILL: issues one write of cmd_fill_data per clock, with no handshake, for len clocks, then DONE.
- READ:
  - A read issue presents host_addr=cur with host_wr_ena=0.
  - A read is issued only when fifo_count + inflight < FIFO_DEPTH, which rules out FIFO overflow.
  - A RD_LATENCY-deep valid shift register tags each returning word; tagged words are pushed into the FIFO.
  - After the last issue, go to DRAIN.
- DRAIN: waits until inflight=0, then DONE. It does not wait for the FIFO to empty, so the consumer may lag.
- DONE: done=1 for one clock, then IDLE.
- host_wr_ena is asserted only for beats actually consumed. It is never high in IDLE, READ, DRAIN or DONE.
- Address arithmetic: cur+step is taken modulo 2**ADDR_BITS. For example, with 16-bit words, 0xFFFFE steps to 0x00000.
- rd_valid=!fifo_empty and rd_data=FIFO head (first-word fall-through). A pop occurs on rd_valid&rd_ready. A push and a pop in the same clock keep the count unchanged.
- cmd_valid while busy is ignored and is not queued.
- Reset mid-burst: the command is abandoned, FIFO contents and in-flight reads are discarded, and done does not pulse.

Optional Feature:
GPU_BURST_STATS_EN.
- Defined:
  - Adds output stat_words[31:0], which counts every host write issued and every read word pushed into the FIFO.
  - Adds input stat_clr, which zeroes the counter synchronously; stat_clr has priority over a same-cycle increment.
  - The counter wraps at 2**32 and is reset to 0 by reset.
- Undefined: neither port exists and no counter logic is built.

Decomposition:
- Package gpu_burst_pkg holds:
  - typedef burst_op_t: WRITE, READ, FILL, NOP.
  - typedef burst_state_t.
  - Constants OP_WRITE/OP_READ/OP_FILL and STEP_8=1, STEP_16=2.
- One sub-module, gpu_burst_rd_fifo:
  - Synchronous FIFO, FIFO_DEPTH x 16, first-word fall-through.
  - Count output, push/pop ports, synchronous clear tied to reset.

Test Plan:
- FILL, addr=0x00100, len=4, 16bit=1, data=0xA5A5 -> host_wr_ena high 4 consecutive clocks at 0x100/0x102/0x104/0x106, each with data 0xA5A5; done pulses once; cmd_ready returns high.
- WRITE, len=3, 8-bit, wr_valid toggling 1,0,1,1 with data 0x11/0x22/0x33 -> exactly 3 writes at addr,addr+1,addr+2 with matching data; no write in the gap cycle.
- READ, len=20, RD_LATENCY=3, FIFO_DEPTH=8, rd_ready held low -> exactly 8 reads issued, then issue stalls; releasing rd_ready yields all 20 words in order, matching the bench memory model.
- WRITE, addr=0xFFFFE, 16bit=1, len=2 -> writes at 0xFFFFE then 0x00000.
- len=0 and op=3 -> done pulses one clock after acceptance; host_wr_ena is never asserted.
- reset asserted mid-READ with 3 reads in flight -> next clock all outputs at reset values; rd_valid stays 0; a following FILL command executes normally.
